vscale_mp_hasti_sram: RTL and testbench

Parametrised N-port HASTI (AHB-Lite) SRAM for vscale simulation and formal tops: NPORTS independent slave ports share one single-ported word array via a round-robin arbiter that inserts wait states on contention. Successor to the fixed dual-port SRAM. Lets multi-core tops hang every core's imem/dmem port on one coherent memory. Exports a flattened window of the array for formal properties.

---
 rtl/vscale_mp_hasti_sram_pkg.sv | 58 +++++
 rtl/vscale_rr_arbiter.sv | 46 ++++
 rtl/vscale_mp_hasti_sram.sv | 143 ++++++++++++++
 tb/tb_vscale_mp_hasti_sram.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_mp_hasti_sram_pkg.sv
// Shared HASTI encodings, slot states and byte-lane helper for the N-port HASTI SRAM.
// VSCALE_SRAM_ERR_RESP_EN adds the ERR1 slot state used by the two-cycle error response.
package vscale_mp_hasti_sram_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;

    typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [HASTI_SIZE_WIDTH-1:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [HASTI_RESP_WIDTH-1:0] {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_DATA = 2'd1
`ifdef VSCALE_SRAM_ERR_RESP_EN
        , SLOT_ERR1 = 2'd2
`endif
    } slot_state_t;

    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [HASTI_SIZE_WIDTH-1:0] size;
    } slot_req_t;

    // Lanes beyond byte 3 fall off the top, so misaligned accesses are clipped to the word.
    function automatic logic [3:0] lane_mask(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                             input logic [1:0] offs);
        logic [6:0] m;
        case (size)
            HSIZE_BYTE: m = 7'b000_0001;
            HSIZE_HALF: m = 7'b000_0011;
            default:    m = 7'b000_1111;
        endcase
        m = m << offs;
        return m[3:0];
    endfunction

endpackage

// File: rtl/vscale_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching upward from the pointer.
// The pointer moves to grant+1 after every grant and holds when nothing is requested.
module vscale_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          any;

    // Two passes: ports at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                gidx     = PW'(i);
                any      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                gidx     = PW'(i);
                any      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            ptr <= '0;
        else if (any)
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/vscale_mp_hasti_sram.sv
// N-port HASTI SRAM: per-port slot FSMs share one word array through a round-robin arbiter.
// Define VSCALE_SRAM_ERR_RESP_EN to return a two-cycle ERROR for word addresses >= NWORDS.
module vscale_mp_hasti_sram
    import vscale_mp_hasti_sram_pkg::*;
#(
    parameter int NPORTS    = 2,
    parameter int NWORDS    = 1024,
    parameter int DBG_WORDS = 32
) (
    input  logic                                        hclk,
    input  logic                                        hresetn,
    input  logic [NPORTS-1:0][HASTI_ADDR_WIDTH-1:0]     p_haddr,
    input  logic [NPORTS-1:0]                           p_hwrite,
    input  logic [NPORTS-1:0][HASTI_SIZE_WIDTH-1:0]     p_hsize,
    input  logic [NPORTS-1:0][HASTI_BURST_WIDTH-1:0]    p_hburst,
    input  logic [NPORTS-1:0]                           p_hmastlock,
    input  logic [NPORTS-1:0][HASTI_PROT_WIDTH-1:0]     p_hprot,
    input  logic [NPORTS-1:0][HASTI_TRANS_WIDTH-1:0]    p_htrans,
    input  logic [NPORTS-1:0][HASTI_BUS_WIDTH-1:0]      p_hwdata,
    output logic [NPORTS-1:0][HASTI_BUS_WIDTH-1:0]      p_hrdata,
    output logic [NPORTS-1:0]                           p_hready,
    output logic [NPORTS-1:0][HASTI_RESP_WIDTH-1:0]     p_hresp,
    output logic [DBG_WORDS-1:0][HASTI_BUS_WIDTH-1:0]   dbg_mem
);

    localparam int AW = $clog2(NWORDS);

    logic [HASTI_BUS_WIDTH-1:0] mem [NWORDS];

    logic [NPORTS-1:0]            req, grant, oob;
    slot_req_t [NPORTS-1:0]       sreq_v;
    slot_req_t                    g_req;
    logic                         g_any, g_fault;
    logic [HASTI_BUS_WIDTH-1:0]   g_wdata, rd_word;
    logic [AW-1:0]                g_widx;
    logic [3:0]                   g_mask;

    vscale_rr_arbiter #(.N(NPORTS)) arb (
        .clk    (hclk),
        .resetn (hresetn),
        .req    (req),
        .grant  (grant)
    );

    always_comb begin
        g_any   = 1'b0;
        g_req   = '0;
        g_wdata = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) begin
                g_any   = 1'b1;
                g_req   = sreq_v[i];
                g_wdata = p_hwdata[i];
            end
        end
    end

    // Upper address bits only matter for the range check; without it the index wraps.
    assign g_widx  = g_req.addr[AW+1:2];
    assign g_mask  = lane_mask(g_req.size, g_req.addr[1:0]);
    assign rd_word = mem[g_widx];

`ifdef VSCALE_SRAM_ERR_RESP_EN
    assign g_fault = |(grant & oob);
`else
    assign g_fault = 1'b0;
`endif

    // Writes are gated by reset so an in-flight data phase is dropped without touching the array.
    always_ff @(posedge hclk) begin
        if (hresetn && g_any && g_req.write && !g_fault) begin
            for (int b = 0; b < 4; b++)
                if (g_mask[b]) mem[g_widx][8*b +: 8] <= g_wdata[8*b +: 8];
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        slot_state_t                st;
        slot_req_t                  sreq;
        logic                       start, hready;
        logic [HASTI_RESP_WIDTH-1:0] hresp;
        logic [HASTI_BUS_WIDTH-1:0] hrdata;

        assign start = (p_htrans[i] == HTRANS_NONSEQ) || (p_htrans[i] == HTRANS_SEQ);
        assign oob[i] = |sreq.addr[HASTI_ADDR_WIDTH-1:AW+2];

        always_comb begin
            hready = 1'b1;
            hresp  = HRESP_OKAY;
            hrdata = '0;
            case (st)
                SLOT_DATA: begin
                    if (!grant[i])
                        hready = 1'b0;
`ifdef VSCALE_SRAM_ERR_RESP_EN
                    else if (oob[i]) begin
                        hready = 1'b0;
                        hresp  = HRESP_ERROR;
                    end
`endif
                    else if (!sreq.write)
                        hrdata = rd_word;
                end
`ifdef VSCALE_SRAM_ERR_RESP_EN
                SLOT_ERR1: hresp = HRESP_ERROR;
`endif
                default: ;
            endcase
        end

        always_ff @(posedge hclk) begin
            if (!hresetn)
                st <= SLOT_IDLE;
`ifdef VSCALE_SRAM_ERR_RESP_EN
            else if (grant[i] && oob[i])
                st <= SLOT_ERR1;
`endif
            else if (hready) begin
                if (start) begin
                    st   <= SLOT_DATA;
                    sreq <= '{addr: p_haddr[i], write: p_hwrite[i], size: p_hsize[i]};
                end else begin
                    st <= SLOT_IDLE;
                end
            end
        end

        assign req[i]      = (st == SLOT_DATA);
        assign sreq_v[i]   = sreq;
        assign p_hready[i] = hready;
        assign p_hresp[i]  = hresp;
        assign p_hrdata[i] = hrdata;
    end

    for (genvar w = 0; w < DBG_WORDS; w++) begin : g_dbg
        assign dbg_mem[w] = mem[AW'(w)];
    end

    // Burst, lock and protection attributes have no effect on a flat SRAM.
    logic unused_sig;
    assign unused_sig = ^{p_hburst, p_hmastlock, p_hprot, oob, g_req.addr};

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
// Self-checking bench for vscale_mp_hasti_sram (3 ports) against a word-array reference model.
// Covers the VSCALE_SRAM_ERR_RESP_EN build as well as the default build.
module tb_vscale_mp_hasti_sram;
    import vscale_mp_hasti_sram_pkg::*;

    localparam int NP = 3;
    localparam int NW = 1024;
    localparam int DW = 32;

    logic                 hclk = 1'b0;
    logic                 hresetn;
    logic [NP-1:0][31:0]  haddr, hwdata, hrdata;
    logic [NP-1:0]        hwrite, hmastlock, hready;
    logic [NP-1:0][2:0]   hsize, hburst;
    logic [NP-1:0][3:0]   hprot;
    logic [NP-1:0][1:0]   htrans;
    logic [NP-1:0][0:0]   hresp;
    logic [DW-1:0][31:0]  dbg_mem;

    logic [31:0] ref_mem [NW];
    int checks, failures;

    vscale_mp_hasti_sram #(.NPORTS(NP), .NWORDS(NW), .DBG_WORDS(DW)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .p_haddr(haddr), .p_hwrite(hwrite), .p_hsize(hsize), .p_hburst(hburst),
        .p_hmastlock(hmastlock), .p_hprot(hprot), .p_htrans(htrans), .p_hwdata(hwdata),
        .p_hrdata(hrdata), .p_hready(hready), .p_hresp(hresp), .dbg_mem(dbg_mem)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic reset_dut();
        hresetn = 1'b0;
        step();
        step();
        hresetn = 1'b1;
    endtask

    // Byte b of the word is written when it lies in [offset, offset + 2^size), bytes past 3 lost.
    task automatic model_write(input logic [31:0] a, input int sz, input logic [31:0] d);
        int w, lo, n;
        w  = int'(a >> 2) % NW;
        lo = int'(a & 32'd3);
        n  = 1 << sz;
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic xfer(input int p, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rdy,
                        output int waits);
        haddr[p]  = a;
        hwrite[p] = wr;
        hsize[p]  = sz;
        htrans[p] = HTRANS_NONSEQ;
        step();
        htrans[p] = HTRANS_IDLE;
        hwdata[p] = wd;
        waits = 0;
        @(negedge hclk);
        while (!hready[p] && waits < 20) begin
            waits++;
            @(negedge hclk);
        end
        rd  = hrdata[p];
        rdy = hready[p];
        step();
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        step();
        step();
        @(negedge hclk);
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (hready[p] !== 1'b1 || hresp[p] !== 1'b0 || hrdata[p] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs port=%0d got ready=%b resp=%b rdata=%h want 1 0 0",
                         p, hready[p], hresp[p], hrdata[p]);
            end
        end
        hresetn = 1'b1;
        htrans[2] = HTRANS_BUSY;
        step();
        @(negedge hclk);
        checks++;
        if (hready[2] !== 1'b1) begin
            failures++;
            $display("FAIL busy_stays_idle got ready=%b want 1", hready[2]);
        end
        htrans[2] = HTRANS_IDLE;
        step();
    endtask

    task automatic test_init();
        logic [31:0] rd, d;
        logic rdy;
        int waits;
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            xfer(w % NP, 1'b1, 32'(w * 4), HSIZE_WORD, d, rd, rdy, waits);
            model_write(32'(w * 4), 2, d);
        end
        checks++;
        if (rdy !== 1'b1 || waits != 0) begin
            failures++;
            $display("FAIL init_write_ready got ready=%b waits=%0d want 1 0", rdy, waits);
        end
    endtask

    task automatic test_single();
        logic [31:0] rd;
        logic rdy;
        int waits;
        xfer(0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, rd, rdy, waits);
        model_write(32'h10, 2, 32'hDEADBEEF);
        checks++;
        if (rdy !== 1'b1 || waits != 0) begin
            failures++;
            $display("FAIL single_write_ready got ready=%b waits=%0d want 1 0", rdy, waits);
        end
        xfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rdy, waits);
        checks++;
        if (rdy !== 1'b1 || waits != 0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_read got rdata=%h waits=%0d want deadbeef 0", rd, waits);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, d;
        logic rdy;
        int waits;
        xfer(1, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, rd, rdy, waits);
        d = {8'hAA, 24'($urandom)};
        xfer(1, 1'b1, 32'h13, HSIZE_BYTE, d, rd, rdy, waits);
        model_write(32'h10, 2, 32'h11223344);
        model_write(32'h13, 0, d);
        xfer(2, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rdy, waits);
        checks++;
        if (rd !== 32'hAA223344) begin
            failures++;
            $display("FAIL byte_write got rdata=%h want aa223344", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d;
        logic rdy, wr;
        int p, sz, waits;
        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(0, NP - 1);
            wr = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 255));
            d  = $urandom;
            xfer(p, wr, a, 3'(sz), d, rd, rdy, waits);
            checks++;
            if (rdy !== 1'b1 || waits != 0) begin
                failures++;
                $display("FAIL rand_ready op=%0d got ready=%b waits=%0d want 1 0", n, rdy, waits);
            end
            if (wr) model_write(a, sz, d);
            else begin
                checks++;
                if (rd !== ref_mem[a >> 2]) begin
                    failures++;
                    $display("FAIL rand_read op=%0d addr=%h got %h want %h", n, a, rd, ref_mem[a >> 2]);
                end
            end
        end
    endtask

    task automatic test_dbg();
        @(negedge hclk);
        for (int w = 0; w < DW; w++) begin
            checks++;
            if (dbg_mem[w] !== ref_mem[w]) begin
                failures++;
                $display("FAIL dbg_mem word=%0d got %h want %h", w, dbg_mem[w], ref_mem[w]);
            end
        end
        step();
    endtask

    task automatic test_contend3();
        int order [3] = '{0, 1, 2};
        logic [NP-1:0] exp_rdy;
        reset_dut();
        for (int p = 0; p < NP; p++) begin
            haddr[p]  = 32'((p + 5) * 4);
            hwrite[p] = 1'b0;
            hsize[p]  = HSIZE_WORD;
            htrans[p] = HTRANS_NONSEQ;
        end
        step();
        htrans = '0;
        exp_rdy = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            exp_rdy = exp_rdy | NP'(1 << order[c]);
            checks++;
            if (hready !== exp_rdy) begin
                failures++;
                $display("FAIL contend_ready cycle=%0d got %b want %b", c, hready, exp_rdy);
            end
            checks++;
            if (hrdata[order[c]] !== ref_mem[order[c] + 5]) begin
                failures++;
                $display("FAIL contend_rdata port=%0d got %h want %h", order[c], hrdata[order[c]],
                         ref_mem[order[c] + 5]);
            end
            step();
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] rd, old;
        logic rdy;
        int waits;
        reset_dut();
        xfer(0, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, rdy, waits);
        old = ref_mem[16];
        haddr[0] = 32'h40; hwrite[0] = 1'b1; hsize[0] = HSIZE_WORD; htrans[0] = HTRANS_NONSEQ;
        haddr[1] = 32'h40; hwrite[1] = 1'b0; hsize[1] = HSIZE_WORD; htrans[1] = HTRANS_NONSEQ;
        step();
        htrans = '0;
        hwdata[0] = 32'h5;
        @(negedge hclk);
        checks++;
        if (hready[1:0] !== 2'b10 || hrdata[1] !== old) begin
            failures++;
            $display("FAIL same_addr_first got ready=%b rdata=%h want 10 %h", hready[1:0], hrdata[1], old);
        end
        step();
        @(negedge hclk);
        checks++;
        if (hready[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL same_addr_second got ready=%b want 11", hready[1:0]);
        end
        step();
        model_write(32'h40, 2, 32'h5);
        xfer(1, 1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, rdy, waits);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL same_addr_after got %h want 00000005", rd);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 16;
        logic [31:0] a [N];
        logic [31:0] d [N];
        logic        wr [N];
        int          sz [N];
        for (int k = 0; k < N; k++) begin
            a[k]  = 32'($urandom_range(0, 255));
            d[k]  = $urandom;
            wr[k] = 1'($urandom_range(0, 1));
            sz[k] = $urandom_range(0, 2);
        end
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                haddr[0]  = a[k];
                hwrite[0] = wr[k];
                hsize[0]  = 3'(sz[k]);
                htrans[0] = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            end else begin
                htrans[0] = HTRANS_IDLE;
            end
            if (k > 0) hwdata[0] = d[k-1];
            @(negedge hclk);
            if (k > 0) begin
                checks++;
                if (hready[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready op=%0d got %b want 1", k - 1, hready[0]);
                end
                if (wr[k-1]) model_write(a[k-1], sz[k-1], d[k-1]);
                else begin
                    checks++;
                    if (hrdata[0] !== ref_mem[a[k-1] >> 2]) begin
                        failures++;
                        $display("FAIL b2b_read op=%0d got %h want %h", k - 1, hrdata[0],
                                 ref_mem[a[k-1] >> 2]);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic rdy;
        int waits, nrdy;
        for (int p = 0; p < 2; p++) begin
            haddr[p] = 32'h7C; hwrite[p] = 1'b1; hsize[p] = HSIZE_WORD; htrans[p] = HTRANS_NONSEQ;
        end
        step();
        htrans = '0;
        hwdata[0] = ~ref_mem[31];
        hwdata[1] = ~ref_mem[31] ^ 32'h1;
        hresetn = 1'b0;
        @(negedge hclk);
        nrdy = int'(hready[0]) + int'(hready[1]);
        checks++;
        if (nrdy != 1) begin
            failures++;
            $display("FAIL mid_reset_contention got ready=%b want exactly one", hready[1:0]);
        end
        step();
        @(negedge hclk);
        checks++;
        if (hready !== '1 || hresp !== '0 || hrdata !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got ready=%b resp=%b want 111 000", hready, hresp);
        end
        hresetn = 1'b1;
        step();
        xfer(2, 1'b0, 32'h7C, HSIZE_WORD, 32'h0, rd, rdy, waits);
        checks++;
        if (rd !== ref_mem[31] || dbg_mem[31] !== ref_mem[31]) begin
            failures++;
            $display("FAIL mid_reset_array got %h dbg=%h want %h", rd, dbg_mem[31], ref_mem[31]);
        end
    endtask

    task automatic test_oob();
        logic [31:0] rd;
        logic rdy;
        int waits;
        haddr[0] = 32'h1000; hwrite[0] = 1'b0; hsize[0] = HSIZE_WORD; htrans[0] = HTRANS_NONSEQ;
        step();
        htrans[0] = HTRANS_IDLE;
        @(negedge hclk);
`ifdef VSCALE_SRAM_ERR_RESP_EN
        checks++;
        if (hready[0] !== 1'b0 || hresp[0] !== HRESP_ERROR) begin
            failures++;
            $display("FAIL oob_cycle1 got ready=%b resp=%b want 0 1", hready[0], hresp[0]);
        end
        step();
        @(negedge hclk);
        checks++;
        if (hready[0] !== 1'b1 || hresp[0] !== HRESP_ERROR) begin
            failures++;
            $display("FAIL oob_cycle2 got ready=%b resp=%b want 1 1", hready[0], hresp[0]);
        end
        step();
        xfer(1, 1'b1, 32'h1004, HSIZE_WORD, 32'hCAFEF00D, rd, rdy, waits);
`else
        checks++;
        if (hready[0] !== 1'b1 || hresp[0] !== HRESP_OKAY || hrdata[0] !== ref_mem[0]) begin
            failures++;
            $display("FAIL oob_wrap got ready=%b resp=%b rdata=%h want 1 0 %h",
                     hready[0], hresp[0], hrdata[0], ref_mem[0]);
        end
        step();
        xfer(1, 1'b1, 32'h1004, HSIZE_WORD, 32'hCAFEF00D, rd, rdy, waits);
        model_write(32'h1004, 2, 32'hCAFEF00D);
`endif
        xfer(2, 1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rdy, waits);
        checks++;
        if (rd !== ref_mem[1]) begin
            failures++;
            $display("FAIL oob_write_effect got %h want %h", rd, ref_mem[1]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        hresetn   = 1'b0;
        haddr     = '0;
        hwrite    = '0;
        hsize     = '0;
        hburst    = '0;
        hmastlock = '0;
        hprot     = '0;
        htrans    = '0;
        hwdata    = '0;
        test_reset();
        test_init();
        test_single();
        test_byte();
        test_random();
        test_dbg();
        test_contend3();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        test_oob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
